mem_bus_access: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus with a transfer FSM and a timeout.
- Raises a stall request while a transfer is outstanding; passes non-memory instructions straight through.

---
 rtl/mem_bus_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_bus_access.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_access.sv
// MEM stage of the 5-stage MIPS pipeline: byte/half/word loads and stores over a req/ack bus,
// with a transfer timeout and a stall request while a transfer is outstanding.
module mem_bus_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_hold_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o,
    output logic        misalign_o
);
    // state  | meaning
    // S_IDLE | no transfer; aligned memory op launches one at the next edge
    // S_WAIT | request on the bus, counting cycles without ack
    // S_DONE | transfer finished (data or timeout), held while mem_hold_i
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_sel_q, bus_sel_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic        is_load, is_store, is_mem, ld_signed, misalign;
    logic [1:0]  size;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n, load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = 2'd2;
        case (aluop_i)
            8'hE0: begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd0; end
            8'hE1: begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd1; end
            8'hE3: begin is_load = 1'b1; size = 2'd2; end
            8'hE4: begin is_load = 1'b1; size = 2'd0; end
            8'hE5: begin is_load = 1'b1; size = 2'd1; end
            8'hE8: begin is_store = 1'b1; size = 2'd0; end
            8'hE9: begin is_store = 1'b1; size = 2'd1; end
            8'hEB: begin is_store = 1'b1; size = 2'd2; end
            default: ;
        endcase
        is_mem   = is_load | is_store;
        misalign = is_mem && (((size == 2'd1) && mem_addr_i[0]) ||
                              ((size == 2'd2) && (mem_addr_i[1:0] != 2'b00)));

        // Big-endian lanes: lowest address sits in bits 31:24.
        case (size)
            2'd0:    begin sel_n = 4'b1000 >> mem_addr_i[1:0]; wdata_n = {4{reg2_i[7:0]}}; end
            2'd1:    begin sel_n = mem_addr_i[1] ? 4'b0011 : 4'b1100; wdata_n = {2{reg2_i[15:0]}}; end
            default: begin sel_n = 4'b1111; wdata_n = reg2_i; end
        endcase

        case (mem_addr_i[1:0])
            2'b00:   lane_b = rdata_q[31:24];
            2'b01:   lane_b = rdata_q[23:16];
            2'b10:   lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size)
            2'd0:    load_data = {{24{ld_signed & lane_b[7]}}, lane_b};
            2'd1:    load_data = {{16{ld_signed & lane_h[15]}}, lane_h};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (is_mem && !misalign) begin
                    state_d     = S_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = sel_n;
                    bus_wdata_d = wdata_n;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            end
            S_WAIT: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (bus_ack_i) begin
                    rdata_d   = bus_rdata_i;
                    bus_req_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        bus_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!mem_hold_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i & ~misalign;
        wdata_o    = wdata_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        stallreq_o = 1'b0;
        bus_err_o  = 1'b0;
        misalign_o = misalign;
        case (state_q)
            S_IDLE: stallreq_o = is_mem & ~misalign;
            S_WAIT: stallreq_o = 1'b1;
            S_DONE: begin
                bus_err_o = err_q;
                if (is_load) begin
                    wdata_o = err_q ? 32'h0 : load_data;
                    if (err_q) wreg_o = 1'b0;
                end
            end
            default: ;
        endcase
        if (!rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            hi_o       = '0;
            lo_o       = '0;
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
            bus_err_o  = 1'b0;
            misalign_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_bus_access.sv
// Directed bench for mem_bus_access (TIMEOUT = 4): pass-through, loads, stores,
// misalignment, timeout and reset mid-transfer.
module tb_mem_bus_access;
    logic        clk = 1'b0;
    logic        rst, mem_hold_i, wreg_i, whilo_i, bus_ack_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, bus_rdata_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o, bus_req_o, bus_we_o, bus_err_o, misalign_o;
    logic [31:0] wdata_o, hi_o, lo_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    int checks = 0;
    int errors = 0;

    mem_bus_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_hold_i(mem_hold_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] wd, input logic wreg);
        aluop_i    = op;
        mem_addr_i = addr;
        wdata_i    = addr;
        reg2_i     = rt;
        wd_i       = wd;
        wreg_i     = wreg;
    endtask

    initial begin
        rst = 1'b0; mem_hold_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        hi_i = 32'h0000_0055; lo_i = 32'h0000_00AA; whilo_i = 1'b1;
        instr(8'h21, 32'h1234, 32'h0, 5'd3, 1'b1);
        tick(); tick();
        // Reset: everything reads 0.
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_stall", stallreq_o, 0);
        chk("rst_req", bus_req_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        rst = 1'b1;
        #1;
        // 1. pass-through
        chk("pt_wd", wd_o, 3);
        chk("pt_wreg", wreg_o, 1);
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_hi", hi_o, 32'h55);
        chk("pt_stall", stallreq_o, 0);
        tick();
        chk("pt_req", bus_req_o, 0);
        chk("pt_wdata2", wdata_o, 32'h1234);

        // 2. LB at 0x1001, ack in the 2nd WAIT cycle
        instr(8'hE0, 32'h1001, 32'h0, 5'd4, 1'b1);
        #1;
        chk("lb_stall_idle", stallreq_o, 1);
        chk("lb_req_idle", bus_req_o, 0);
        chk("lb_misalign", misalign_o, 0);
        tick();
        chk("lb_req_w1", bus_req_o, 1);
        chk("lb_sel", bus_sel_o, 4'b0100);
        chk("lb_addr", bus_addr_o, 32'h1000);
        chk("lb_we", bus_we_o, 0);
        chk("lb_stall_w1", stallreq_o, 1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h00F0_0000;
        #1;
        chk("lb_req_w2", bus_req_o, 1);
        chk("lb_stall_w2", stallreq_o, 1);
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("lb_stall_done", stallreq_o, 0);
        chk("lb_req_done", bus_req_o, 0);
        chk("lb_data", wdata_o, 32'hFFFF_FFF0);
        chk("lb_wreg", wreg_o, 1);
        chk("lb_err", bus_err_o, 0);
        // LBU, same address, ack in first WAIT cycle
        instr(8'hE4, 32'h1001, 32'h0, 5'd4, 1'b1);
        tick();
        chk("lbu_stall_idle", stallreq_o, 1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h00F0_0000;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        mem_hold_i = 1'b1;
        #1;
        chk("lbu_data", wdata_o, 32'h0000_00F0);
        tick();
        chk("hold_stall", stallreq_o, 0);
        chk("hold_data", wdata_o, 32'h0000_00F0);
        chk("hold_req", bus_req_o, 0);
        mem_hold_i = 1'b0;

        // 3. SH at 0x2002
        instr(8'hE9, 32'h2002, 32'hAAAA_5678, 5'd0, 1'b0);
        tick();
        chk("sh_stall_idle", stallreq_o, 1);
        tick();
        chk("sh_req", bus_req_o, 1);
        chk("sh_we", bus_we_o, 1);
        chk("sh_sel", bus_sel_o, 4'b0011);
        chk("sh_wdata", bus_wdata_o, 32'h5678_5678);
        chk("sh_addr", bus_addr_o, 32'h2000);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("sh_req_after_ack", bus_req_o, 0);
        chk("sh_wreg", wreg_o, 0);
        chk("sh_stall_done", stallreq_o, 0);

        // 4. misaligned LW at 0x3002
        instr(8'hE3, 32'h3002, 32'h0, 5'd7, 1'b1);
        tick();
        chk("mis_flag", misalign_o, 1);
        chk("mis_wreg", wreg_o, 0);
        chk("mis_stall", stallreq_o, 0);
        tick();
        chk("mis_req", bus_req_o, 0);
        chk("mis_flag2", misalign_o, 1);

        // 5. LW timeout with TIMEOUT = 4
        instr(8'hE3, 32'h4000, 32'h0, 5'd8, 1'b1);
        #1;
        chk("to_misalign", misalign_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_req_high", bus_req_o, 1);
        end
        tick();
        chk("to_req_drop", bus_req_o, 0);
        chk("to_err", bus_err_o, 1);
        chk("to_wreg", wreg_o, 0);
        chk("to_wdata", wdata_o, 0);
        chk("to_stall", stallreq_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D; mem_hold_i = 1'b1;
        tick();
        chk("late_ack_err", bus_err_o, 1);
        chk("late_ack_wdata", wdata_o, 0);
        chk("late_ack_req", bus_req_o, 0);
        bus_ack_i = 1'b0; mem_hold_i = 1'b0;

        // 6. reset mid-WAIT on an LW at 0x5000
        instr(8'hE3, 32'h5000, 32'h0, 5'd9, 1'b1);
        tick();
        tick();
        chk("rw_req", bus_req_o, 1);
        rst = 1'b0;
        tick();
        chk("rw_req_rst", bus_req_o, 0);
        chk("rw_addr_rst", bus_addr_o, 0);
        chk("rw_stall_rst", stallreq_o, 0);
        chk("rw_wreg_rst", wreg_o, 0);
        rst = 1'b1;
        #1;
        chk("rw_stall_idle", stallreq_o, 1);
        chk("rw_req_idle", bus_req_o, 0);
        tick();
        chk("rw_req_reissue", bus_req_o, 1);
        chk("rw_addr", bus_addr_o, 32'h5000);
        chk("rw_sel", bus_sel_o, 4'b1111);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("rw_data", wdata_o, 32'h1234_5678);
        chk("rw_wreg", wreg_o, 1);
        chk("rw_err", bus_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
